hqc_fw_sampler: RTL and testbench

Front end of the fixed-weight vector generator, directly upstream of `hqc_barrett_red`. It unpacks the 32-bit SHAKE output stream into little-endian 24-bit candidates and rejects candidates at or above the per-set rejection threshold. Accepted candidates go out on a valid/ready port, which feeds the Barrett reducer's `a_i`. It stops after exactly `weight_i` accepted candidates have been handed out.

---
 rtl/hqc_fw_params.sv | 31 +++
 rtl/hqc_fw_sampler_if.sv | 23 ++
 rtl/hqc_fw_byte_buf.sv | 48 ++++
 rtl/hqc_fw_sampler.sv | 126 ++++++++++++
 tb/tb_hqc_fw_sampler.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hqc_fw_params.sv
// Shared constants for the HQC fixed-weight vector generator: per-set code length,
// rejection threshold, weights and stream widths.
package hqc_fw_params;

  localparam int WORD_W = 32;
  localparam int CAND_W = 24;
  localparam int BUF_W  = 48;

  localparam int N_128 = 17669;
  localparam int N_192 = 35851;
  localparam int N_256 = 57637;

  // floor(2^24 / N) * N for each set
  localparam logic [CAND_W-1:0] THR_128 = 24'd16767881;
  localparam logic [CAND_W-1:0] THR_192 = 24'd16742417;
  localparam logic [CAND_W-1:0] THR_256 = 24'd16772367;

  localparam int OMEGA_128   = 66;
  localparam int OMEGA_R_128 = 75;
  localparam int OMEGA_192   = 100;
  localparam int OMEGA_R_192 = 114;
  localparam int OMEGA_256   = 131;
  localparam int OMEGA_R_256 = 149;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fw_state_e;

endpackage

// File: rtl/hqc_fw_sampler_if.sv
// Stream bundle of the sampler: SHAKE words in, accepted 24-bit candidates out.
// Both streams use valid/ready: a beat transfers on a rising edge where valid and
// ready are both high; the producer holds data and valid stable until it transfers.
interface hqc_fw_sampler_if;

  logic [hqc_fw_params::WORD_W-1:0] word_i;
  logic                             word_valid_i;
  logic                             word_ready_o;
  logic [hqc_fw_params::CAND_W-1:0] a_o;
  logic                             a_valid_o;
  logic                             a_ready_i;

  modport slave (
    input  word_i, word_valid_i, a_ready_i,
    output word_ready_o, a_o, a_valid_o
  );

  modport master (
    output word_i, word_valid_i, a_ready_i,
    input  word_ready_o, a_o, a_valid_o
  );

endinterface

// File: rtl/hqc_fw_byte_buf.sv
// 48-bit little-endian byte buffer: pops 3 bytes from the bottom, appends a 4-byte
// word above whatever remains after the pop of the same cycle.
module hqc_fw_byte_buf
  import hqc_fw_params::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [CAND_W-1:0] head_o,
  output logic [2:0]        cnt_o
);

  logic [BUF_W-1:0] data_q, data_d, kept;
  logic [2:0]       cnt_q, cnt_d, kept_cnt;

  // The caller only pushes when at most 2 bytes survive the pop, so the word fits.
  always_comb begin
    kept     = pop_i ? (data_q >> CAND_W) : data_q;
    kept_cnt = pop_i ? (cnt_q - 3'd3) : cnt_q;
    data_d   = kept;
    cnt_d    = kept_cnt;
    if (push_i) begin
      data_d = kept | ({{(BUF_W-WORD_W){1'b0}}, push_data_i} << {kept_cnt, 3'b000});
      cnt_d  = kept_cnt + 3'd4;
    end
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o = data_q[CAND_W-1:0];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/hqc_fw_sampler.sv
// Fixed-weight sampler front end: unpacks SHAKE words into 24-bit candidates,
// rejects those at or above THRESHOLD and hands out exactly weight accepted ones.
module hqc_fw_sampler
  import hqc_fw_params::*;
#(
  parameter string parameter_set = "hqc128"
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [7:0]             weight_i,
  hqc_fw_sampler_if.slave        bus,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [7:0]             rej_cnt_o,
  output fw_state_e              state_o
);

  localparam logic [CAND_W-1:0] THRESH =
    (parameter_set == "hqc256") ? THR_256 :
    (parameter_set == "hqc192") ? THR_192 : THR_128;

  fw_state_e         state_q, state_d;
  logic [7:0]        weight_q, weight_d;
  logic [7:0]        issued_q, issued_d;
  logic [7:0]        handed_q, handed_d;
  logic [7:0]        rej_q, rej_d;
  logic [CAND_W-1:0] a_q, a_d;
  logic              a_valid_q, a_valid_d;

  logic              clr, pop, push, word_ready, hs, accept;
  logic [CAND_W-1:0] cand;
  logic [2:0]        cnt;

  hqc_fw_byte_buf u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr),
    .push_i      (push),
    .push_data_i (bus.word_i),
    .pop_i       (pop),
    .head_o      (cand),
    .cnt_o       (cnt)
  );

  always_comb begin
    state_d    = state_q;
    weight_d   = weight_q;
    issued_d   = issued_q;
    handed_d   = handed_q;
    rej_d      = rej_q;
    a_d        = a_q;
    a_valid_d  = a_valid_q;
    clr        = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    word_ready = 1'b0;
    hs         = a_valid_q && bus.a_ready_i;
    accept     = cand < THRESH;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_RUN;
          weight_d = weight_i;
          issued_d = '0;
          handed_d = '0;
          rej_d    = '0;
          clr      = 1'b1;
        end
      end
      ST_RUN: begin
        // The output register may be refilled in the same cycle it is handed out.
        pop        = (cnt >= 3'd3) && (!a_valid_q || bus.a_ready_i) && (issued_q < weight_q);
        word_ready = (issued_q < weight_q) && ((cnt <= 3'd2) || ((cnt <= 3'd5) && pop));
        push       = word_ready && bus.word_valid_i;
        if (hs) begin
          a_valid_d = 1'b0;
          handed_d  = handed_q + 8'd1;
        end
        if (pop) begin
          if (accept) begin
            a_d       = cand;
            a_valid_d = 1'b1;
            issued_d  = issued_q + 8'd1;
          end else if (rej_q != 8'hFF) begin
            rej_d = rej_q + 8'd1;
          end
        end
        if ((weight_q == 8'd0) || (hs && (handed_q == weight_q - 8'd1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      weight_q  <= '0;
      issued_q  <= '0;
      handed_q  <= '0;
      rej_q     <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      weight_q  <= weight_d;
      issued_q  <= issued_d;
      handed_q  <= handed_d;
      rej_q     <= rej_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
    end
  end

  assign bus.word_ready_o = word_ready;
  assign bus.a_o          = a_q;
  assign bus.a_valid_o    = a_valid_q;
  assign busy_o           = (state_q == ST_RUN);
  assign done_o           = (state_q == ST_DONE);
  assign rej_cnt_o        = rej_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_hqc_fw_sampler.sv
// Directed bench for hqc_fw_sampler: three instances (one per parameter set) share
// the stimulus; one of them is selected as the observed target per test.
module tb_hqc_fw_sampler;
  import hqc_fw_params::*;

  // Thresholds re-derived here as floor(2^24/N)*N.
  localparam int T128 = (1 << 24) / 17669 * 17669;
  localparam int T192 = (1 << 24) / 35851 * 35851;
  localparam int T256 = (1 << 24) / 57637 * 57637;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d = 1'b1;
  logic        start_d = 1'b0;
  logic [7:0]  weight_d = '0;
  logic [31:0] word_d = '0;
  logic        word_valid_d = 1'b0;
  logic        a_ready_d = 1'b0;

  hqc_fw_sampler_if if128 ();
  hqc_fw_sampler_if if192 ();
  hqc_fw_sampler_if if256 ();

  assign if128.word_i = word_d;  assign if128.word_valid_i = word_valid_d;  assign if128.a_ready_i = a_ready_d;
  assign if192.word_i = word_d;  assign if192.word_valid_i = word_valid_d;  assign if192.a_ready_i = a_ready_d;
  assign if256.word_i = word_d;  assign if256.word_valid_i = word_valid_d;  assign if256.a_ready_i = a_ready_d;

  logic [2:0] busy_v, done_v;
  logic [7:0] rej_v [3];
  fw_state_e  st_v [3];

  hqc_fw_sampler #(.parameter_set("hqc128")) dut128 (
    .clk_i(clk), .rst_i(rst_d), .start_i(start_d), .weight_i(weight_d), .bus(if128),
    .busy_o(busy_v[0]), .done_o(done_v[0]), .rej_cnt_o(rej_v[0]), .state_o(st_v[0]));
  hqc_fw_sampler #(.parameter_set("hqc192")) dut192 (
    .clk_i(clk), .rst_i(rst_d), .start_i(start_d), .weight_i(weight_d), .bus(if192),
    .busy_o(busy_v[1]), .done_o(done_v[1]), .rej_cnt_o(rej_v[1]), .state_o(st_v[1]));
  hqc_fw_sampler #(.parameter_set("hqc256")) dut256 (
    .clk_i(clk), .rst_i(rst_d), .start_i(start_d), .weight_i(weight_d), .bus(if256),
    .busy_o(busy_v[2]), .done_o(done_v[2]), .rej_cnt_o(rej_v[2]), .state_o(st_v[2]));

  int          sel = 0;
  logic        obs_word_ready, obs_a_valid, obs_busy, obs_done;
  logic [23:0] obs_a;
  logic [7:0]  obs_rej;
  logic [1:0]  obs_state;

  always_comb begin
    obs_word_ready = if128.word_ready_o;
    obs_a_valid    = if128.a_valid_o;
    obs_a          = if128.a_o;
    obs_busy       = busy_v[0];
    obs_done       = done_v[0];
    obs_rej        = rej_v[0];
    obs_state      = st_v[0];
    case (sel)
      1: begin
        obs_word_ready = if192.word_ready_o; obs_a_valid = if192.a_valid_o; obs_a = if192.a_o;
        obs_busy = busy_v[1]; obs_done = done_v[1]; obs_rej = rej_v[1]; obs_state = st_v[1];
      end
      2: begin
        obs_word_ready = if256.word_ready_o; obs_a_valid = if256.a_valid_o; obs_a = if256.a_o;
        obs_busy = busy_v[2]; obs_done = done_v[2]; obs_rej = rej_v[2]; obs_state = st_v[2];
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] word_q[$];
  logic [7:0]  bq[$];
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  int          t_q[$];
  int          cyc = 0;
  int          taken = 0;
  int          n_rej_exp = 0;
  bit          took = 1'b0;
  bit          bp_en = 1'b0;
  bit          ready_fix = 1'b1;
  bit          stall_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [23:0] prev_a = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- word feeder and output monitor (negedge) ----------------
  always @(negedge clk) begin
    cyc++;
    if (took && word_q.size() > 0) void'(word_q.pop_front());
    word_valid_d = word_q.size() > 0;
    word_d       = (word_q.size() > 0) ? word_q[0] : 32'h0;
    a_ready_d    = bp_en ? 1'($urandom_range(0, 1)) : ready_fix;
    #1;
    if (stall_chk && prev_stall) begin
      check("stall_valid", {31'd0, obs_a_valid}, 32'd1);
      check("stall_data", {8'd0, obs_a}, {8'd0, prev_a});
    end
    prev_stall = obs_a_valid && !a_ready_d;
    prev_a     = obs_a;
    took       = word_valid_d && obs_word_ready && !rst_d;
    if (took) taken++;
    if (obs_a_valid && a_ready_d && !rst_d) begin
      got_q.push_back(obs_a);
      t_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_d = 1'b1;
    tick();
    tick();
    word_q.delete();
    exp_q.delete();
    n_rej_exp = 0;
    rst_d = 1'b0;
    tick();
  endtask

  task automatic add_cand(input logic [23:0] c, input int thr);
    bq.push_back(c[7:0]);
    bq.push_back(c[15:8]);
    bq.push_back(c[23:16]);
    if (int'(c) < thr) exp_q.push_back(c);
    else if (n_rej_exp < 255) n_rej_exp++;
  endtask

  task automatic flush_words();
    logic [31:0] w;
    while (bq.size() > 0) begin
      w = '0;
      for (int k = 0; k < 4; k++) if (bq.size() > 0) w[8*k +: 8] = bq.pop_front();
      word_q.push_back(w);
    end
  endtask

  task automatic start_run(input logic [7:0] w);
    weight_d = w;
    start_d  = 1'b1;
    tick();
    start_d  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (obs_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_stream(input string tag, input int g0);
    check({tag, "_count"}, got_q.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (g0 + i < got_q.size()) check(tag, {8'd0, got_q[g0+i]}, {8'd0, exp_q[i]});
      else check({tag, "_missing"}, 32'd0, {8'd0, exp_q[i]});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_a_valid"},    {31'd0, obs_a_valid},    32'd0);
    check({tag, "_a"},          {8'd0, obs_a},           32'd0);
    check({tag, "_busy"},       {31'd0, obs_busy},       32'd0);
    check({tag, "_done"},       {31'd0, obs_done},       32'd0);
    check({tag, "_rej"},        {24'd0, obs_rej},        32'd0);
    check({tag, "_word_ready"}, {31'd0, obs_word_ready}, 32'd0);
    check({tag, "_state"},      {30'd0, obs_state},      32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int g0, t0;
    logic [23:0] c;

    tick();
    check_idle_outputs("reset");
    do_reset();

    // Byte order: four accepted candidates in consecutive cycles.
    sel = 0; ready_fix = 1'b1;
    word_q.push_back(32'h44332211);
    word_q.push_back(32'h88776655);
    word_q.push_back(32'hCCBBAA99);
    exp_q.push_back(24'h332211); exp_q.push_back(24'h665544);
    exp_q.push_back(24'h998877); exp_q.push_back(24'hCCBBAA);
    g0 = got_q.size();
    start_run(8'd4);
    wait_done("order_done", 50);
    check_stream("order", g0);
    for (int i = 1; i < 4; i++)
      if (g0 + i < t_q.size()) check("order_back_to_back", t_q[g0+i] - t_q[g0+i-1], 1);
    check("order_rej", {24'd0, obs_rej}, 32'd0);
    tick();
    check("order_done_pulse", {31'd0, obs_done}, 32'd0);

    // Threshold boundary for hqc128.
    do_reset();
    add_cand(24'(T128 - 1), T128);
    add_cand(24'(T128), T128);
    add_cand(24'hFFFFFF, T128);
    add_cand(24'h000000, T128);
    flush_words();
    g0 = got_q.size();
    start_run(8'd2);
    wait_done("thr128_done", 50);
    check_stream("thr128", g0);
    check("thr128_rej", {24'd0, obs_rej}, 32'd2);

    // Zero weight: done two cycles after start, nothing consumed.
    do_reset();
    word_q.push_back(32'h01020304);
    word_q.push_back(32'h05060708);
    g0 = got_q.size(); t0 = taken;
    start_run(8'd0);
    check("zero_busy", {31'd0, obs_busy}, 32'd1);
    check("zero_done_early", {31'd0, obs_done}, 32'd0);
    tick();
    check("zero_done", {31'd0, obs_done}, 32'd1);
    check("zero_busy_in_done", {31'd0, obs_busy}, 32'd0);
    tick();
    check("zero_done_low", {31'd0, obs_done}, 32'd0);
    check("zero_words_taken", taken - t0, 0);
    check("zero_samples", got_q.size() - g0, 0);

    // Per-set thresholds: THRESHOLD-1 accepted, THRESHOLD rejected.
    do_reset();
    sel = 1;
    add_cand(24'(T192 - 1), T192);
    add_cand(24'(T192), T192);
    add_cand(24'h000005, T192);
    flush_words();
    g0 = got_q.size();
    start_run(8'd2);
    wait_done("thr192_done", 50);
    check_stream("thr192", g0);
    check("thr192_rej", {24'd0, obs_rej}, 32'd1);

    do_reset();
    sel = 2;
    add_cand(24'(T256 - 1), T256);
    add_cand(24'(T256), T256);
    add_cand(24'h000007, T256);
    flush_words();
    g0 = got_q.size();
    start_run(8'd2);
    wait_done("thr256_done", 50);
    check_stream("thr256", g0);
    check("thr256_rej", {24'd0, obs_rej}, 32'd1);

    // Backpressure over 66 samples; first a held stall to see word_ready drop.
    do_reset();
    sel = 0; ready_fix = 1'b0;
    while (exp_q.size() < 66) add_cand(24'($urandom_range(0, 32'h00FFFFFF)), T128);
    flush_words();
    g0 = got_q.size(); t0 = taken;
    start_run(8'd66);
    for (int i = 0; i < 6; i++) tick();
    check("bp_word_ready_low", {31'd0, obs_word_ready}, 32'd0);
    check("bp_words_in_stall", taken - t0, 2);
    check("bp_a_valid_held", {31'd0, obs_a_valid}, 32'd1);
    bp_en = 1'b1; stall_chk = 1'b1;
    wait_done("bp_done", 2000);
    bp_en = 1'b0; stall_chk = 1'b0; ready_fix = 1'b1;
    check_stream("bp", g0);
    check("bp_rej", {24'd0, obs_rej}, n_rej_exp);

    // Asynchronous reset mid-run, then a fresh run from new words only.
    do_reset();
    add_cand(24'hFFFFFF, T128);
    for (int i = 0; i < 20; i++) add_cand(24'($urandom_range(0, T128 - 1)), T128);
    flush_words();
    g0 = got_q.size();
    start_run(8'd20);
    for (int i = 0; i < 200 && (got_q.size() - g0) < 10; i++) tick();
    check("rst_reached_10", {31'd0, (got_q.size() - g0) >= 10}, 32'd1);
    rst_d = 1'b1;
    #1;
    check_idle_outputs("rst_async");
    tick();
    tick();
    word_q.delete();
    exp_q.delete();
    n_rej_exp = 0;
    rst_d = 1'b0;
    tick();
    c = 24'h123456; add_cand(c, T128);
    c = 24'h00ABCD; add_cand(c, T128);
    c = 24'h7FFFFF; add_cand(c, T128);
    flush_words();
    g0 = got_q.size(); t0 = taken;
    start_run(8'd3);
    wait_done("fresh_done", 50);
    tick();
    check_stream("fresh", g0);
    check("fresh_words", taken - t0, 3);
    check("fresh_rej", {24'd0, obs_rej}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
